// File: rtl/mem_access_ctrl.sv
// Memory access controller: MAR/MDR bus consumer that sequences SRAM read and
// write cycles with a programmable number of wait states.
module mem_access_ctrl #(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] Bus,
  input  logic        LD_MAR,
  input  logic        LD_MDR,
  input  logic        Start_Read,
  input  logic        Start_Write,
  input  logic [15:0] Mem_rdata,
  output logic [15:0] MAR,
  output logic [15:0] MDR,
  output logic [15:0] Mem_addr,
  output logic [15:0] Mem_wdata,
  output logic        Mem_CE,
  output logic        Mem_OE,
  output logic        Mem_WE,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t      state_reg, state_next;
  logic [3:0]  count_reg, count_next;
  logic [15:0] mar_reg, mar_next;
  logic [15:0] mdr_reg, mdr_next;
  logic        ce_reg, ce_next;
  logic        oe_reg, oe_next;
  logic        we_reg, we_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= IDLE;
      count_reg <= 4'd0;
      mar_reg   <= 16'h0000;
      mdr_reg   <= 16'h0000;
      ce_reg    <= 1'b1;
      oe_reg    <= 1'b1;
      we_reg    <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      mar_reg   <= mar_next;
      mdr_reg   <= mdr_next;
      ce_reg    <= ce_next;
      oe_reg    <= oe_next;
      we_reg    <= we_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    mar_next   = mar_reg;
    mdr_next   = mdr_reg;
    case (state_reg)
      IDLE: begin
        if (LD_MAR) mar_next = Bus;
        if (LD_MDR) mdr_next = Bus;
        if (Start_Read) begin
          state_next = READ;
          count_next = WAIT_INIT;
        end else if (Start_Write) begin
          state_next = WRITE;
          count_next = WAIT_INIT;
        end
      end
      READ: begin
        if (count_reg == 4'd0) begin
          mdr_next   = Mem_rdata;
          state_next = DONE;
        end else begin
          count_next = count_reg - 4'd1;
        end
      end
      WRITE: begin
        if (count_reg == 4'd0) state_next = DONE;
        else                   count_next = count_reg - 4'd1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Strobes are decoded from the next state so they leave straight from flops.
    ce_next   = !((state_next == READ) || (state_next == WRITE));
    oe_next   = (state_next != READ);
    we_next   = (state_next != WRITE);
    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
  end

  assign MAR       = mar_reg;
  assign MDR       = mdr_reg;
  assign Mem_addr  = mar_reg;
  assign Mem_wdata = mdr_reg;
  assign Mem_CE    = ce_reg;
  assign Mem_OE    = oe_reg;
  assign Mem_WE    = we_reg;
  assign Busy      = busy_reg;
  assign Done      = done_reg;

endmodule
